btb_update_ctrl: RTL and testbench
==================================

// Module: btb_update_ctrl
// PURPOSE
// Sequences every write into the 32-entry branch target buffer (target predictor) used by fetch.
// Three sources of BTB writes are merged onto the single BTB write port:
//   - branch resolutions from execute, queued in a small FIFO;
//   - a full-table invalidate sweep after reset or flush;
//   - conflict deferral, so that a write never lands on the index fetch is reading (bounded by an anti-starvation limit).
// PARAMETERS
// DEPTH       4   resolution FIFO entries (power of 2, >=2)
// INDEX_BITS  5   BTB index width; BTB_SIZE = 2**INDEX_BITS
// TAG_BITS    5   tag stored per entry
// TGT_BITS    10  low target bits stored per entry
// MAX_DEFER   3   max consecutive conflict deferrals before a forced write
// PORTS
// clk           in   1           clock
// reset         in   1           synchronous, active-high
// res_valid     in   1           execute presents a resolved branch
// res_ready     out  1           FIFO accepts; push when res_valid && res_ready
// res_addr      in   64          branch PC
// res_target    in   64          resolved target
// res_taken     in   1           1 = install/overwrite entry, 0 = invalidate entry
// flush_req     in   1           invalidate whole BTB (single-cycle pulse)
// lookup_valid  in   1           fetch reads BTB this cycle
// lookup_index  in   INDEX_BITS  index fetch reads
// btb_we        out  1           BTB write enable (BTB writes at this clk edge)
// btb_windex    out  INDEX_BITS  write index
// btb_wtag      out  TAG_BITS    write tag
// btb_wtarget   out  TGT_BITS    write target bits
// btb_wvalid    out  1           valid bit written
// busy          out  1           sweep active or FIFO non-empty
// sweep_done    out  1           one-cycle pulse, cycle after last sweep write
// BEHAVIOUR
// - Field split: index = res_addr[INDEX_BITS-1:0]; tag = res_addr[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
//   target = res_target[TGT_BITS-1:0]; all captured at push time.
// - FSM states: SWEEP, IDLE. Registered: state, sweep_cnt, FIFO pointers/count, defer_cnt, sweep_done.
// - Write-port outputs are combinational from registered state, FIFO head and lookup inputs.
// - Reset (sampled at edge): state=SWEEP, sweep_cnt=0, FIFO empty, defer_cnt=0, sweep_done=0.
//   Outputs the following cycle: btb_we=1, btb_windex=0, btb_wvalid=0, btb_wtag=0, btb_wtarget=0,
//   res_ready=0, busy=1, sweep_done=0.
// SWEEP
// - Each cycle: btb_we=1, windex=sweep_cnt, wvalid=0, wtag=0, wtarget=0; sweep_cnt++.
// - Lookup conflicts are ignored; fetch sees misses during the sweep.
// - At sweep_cnt = 2**INDEX_BITS-1 the write is issued and the next state is IDLE; sweep_done=1 next cycle.
// - Sweep takes exactly 2**INDEX_BITS cycles (32 at default).
// - res_ready=0 throughout the sweep; the FIFO is held empty.
// IDLE
// - res_ready = (count < DEPTH). A push while full is not possible; no push-pop bypass.
//   An empty FIFO never writes on the cycle of the push: a pushed entry is earliest written the next cycle.
// - Head write condition: FIFO non-empty AND
//   (!(lookup_valid && lookup_index==head.index) OR defer_cnt==MAX_DEFER).
// - On write: btb_we=1, windex/wtag/wtarget from head, wvalid=head.taken; pop; defer_cnt=0.
// - On a conflict without a write: btb_we=0, defer_cnt++ (saturates at MAX_DEFER).
// - FIFO empty: btb_we=0, all write fields 0, defer_cnt=0.
// - Simultaneous push and pop: count unchanged; ordering is strictly FIFO.
// - Pointers wrap modulo DEPTH; count is 0..DEPTH.
// FLUSH
// - flush_req in any state: the current cycle's outputs are unaffected.
// - Next edge: FIFO emptied (a push in the same cycle is discarded), defer_cnt=0, state=SWEEP, sweep_cnt=0.
// - flush_req during SWEEP restarts the sweep from index 0.
// - reset has priority over flush_req.
// - busy = (state==SWEEP) || (count!=0).
// TESTING
// T1 reset, idle inputs -> btb_we=1 for 32 cycles, windex 0..31, wvalid=0;
//    sweep_done=1 on the 33rd cycle; res_ready=1 after.
// T2 push addr=0x1234, target=0x2A8, taken=1, no lookup -> next cycle:
//    we=1, windex=0x14, wtag=0x11, wtarget=0x2A8, wvalid=1.
// T3 push addr=0x14 taken; lookup_valid=1, lookup_index=0x14 held
//    -> we=0 for 3 cycles, forced write on the 4th cycle.
// T4 push 4 entries with no drain (conflict held) -> res_ready=0, 5th res_valid not accepted;
//    entries drain in push order.
// T5 flush_req with 2 queued entries -> queue dropped, sweep 0..31 restarts, queued entries never written.
// T6 push not-taken addr=0x7 -> we=1, windex=7, wvalid=0.
//    Flush at sweep index 17 -> restarts at 0, 32 more writes.

Source files
------------

// File: rtl/btb_update_ctrl_if.sv
// rtl/btb_update_ctrl_if.sv - resolution, lookup and BTB write-port signals of btb_update_ctrl
interface btb_update_ctrl_if #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 5,
  parameter int TGT_BITS   = 10
);
  logic                  res_valid;
  logic                  res_ready;
  logic [63:0]           res_addr;
  logic [63:0]           res_target;
  logic                  res_taken;
  logic                  lookup_valid;
  logic [INDEX_BITS-1:0] lookup_index;
  logic                  btb_we;
  logic [INDEX_BITS-1:0] btb_windex;
  logic [TAG_BITS-1:0]   btb_wtag;
  logic [TGT_BITS-1:0]   btb_wtarget;
  logic                  btb_wvalid;

  modport master (
    output res_valid, res_addr, res_target, res_taken, lookup_valid, lookup_index,
    input  res_ready, btb_we, btb_windex, btb_wtag, btb_wtarget, btb_wvalid
  );

  modport slave (
    input  res_valid, res_addr, res_target, res_taken, lookup_valid, lookup_index,
    output res_ready, btb_we, btb_windex, btb_wtag, btb_wtarget, btb_wvalid
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - merges resolution FIFO, invalidate sweep and fetch-conflict deferral onto the BTB write port
module btb_update_ctrl #(
  parameter int DEPTH      = 4,
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 5,
  parameter int TGT_BITS   = 10,
  parameter int MAX_DEFER  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_req,
  btb_update_ctrl_if.slave    bus,
  output logic                busy,
  output logic                sweep_done
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DEF_W = $clog2(MAX_DEFER + 1);
  localparam logic [CNT_W-1:0]      DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [DEF_W-1:0]      DEFER_MAX_C = DEF_W'(MAX_DEFER);
  localparam logic [INDEX_BITS-1:0] LAST_IDX    = '1;

  typedef enum logic {SWEEP, IDLE} state_t;
  state_t state, state_next;

  logic [INDEX_BITS-1:0] sweep_cnt;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [DEF_W-1:0]      defer_cnt;

  logic [INDEX_BITS-1:0] q_index  [DEPTH];
  logic [TAG_BITS-1:0]   q_tag    [DEPTH];
  logic [TGT_BITS-1:0]   q_target [DEPTH];
  logic                  q_taken  [DEPTH];

  logic                  we, wvalid, ready, do_pop, push, fifo_empty, conflict;
  logic [INDEX_BITS-1:0] windex;
  logic [TAG_BITS-1:0]   wtag;
  logic [TGT_BITS-1:0]   wtarget;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.res_addr[63:INDEX_BITS+TAG_BITS], bus.res_target[63:TGT_BITS]};

  assign fifo_empty = (count == '0);
  assign conflict   = bus.lookup_valid && (bus.lookup_index == q_index[rd_ptr]);
  assign push       = bus.res_valid && ready;

  always_comb begin
    state_next = state;
    we         = 1'b0;
    windex     = '0;
    wtag       = '0;
    wtarget    = '0;
    wvalid     = 1'b0;
    ready      = 1'b0;
    do_pop     = 1'b0;
    case (state)
      SWEEP: begin
        we     = 1'b1;
        windex = sweep_cnt;
        if (sweep_cnt == LAST_IDX) state_next = IDLE;
      end
      IDLE: begin
        ready = (count < DEPTH_C);
        // After MAX_DEFER deferrals the head is written even if fetch reads the same index
        if (!fifo_empty && (!conflict || defer_cnt == DEFER_MAX_C)) begin
          we      = 1'b1;
          windex  = q_index[rd_ptr];
          wtag    = q_tag[rd_ptr];
          wtarget = q_target[rd_ptr];
          wvalid  = q_taken[rd_ptr];
          do_pop  = 1'b1;
        end
      end
      default: state_next = SWEEP;
    endcase
    if (flush_req) state_next = SWEEP;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SWEEP;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_req) begin
      sweep_cnt  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      defer_cnt  <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= (state == SWEEP) && (sweep_cnt == LAST_IDX);
      if (state == SWEEP) sweep_cnt <= sweep_cnt + 1'b1;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == IDLE) begin
        if (fifo_empty || do_pop)                     defer_cnt <= '0;
        else if (conflict && defer_cnt != DEFER_MAX_C) defer_cnt <= defer_cnt + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      q_index[wr_ptr]  <= bus.res_addr[INDEX_BITS-1:0];
      q_tag[wr_ptr]    <= bus.res_addr[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
      q_target[wr_ptr] <= bus.res_target[TGT_BITS-1:0];
      q_taken[wr_ptr]  <= bus.res_taken;
    end
  end

  assign bus.btb_we      = we;
  assign bus.btb_windex  = windex;
  assign bus.btb_wtag    = wtag;
  assign bus.btb_wtarget = wtarget;
  assign bus.btb_wvalid  = wvalid;
  assign bus.res_ready   = ready;
  assign busy            = (state == SWEEP) || !fifo_empty;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - directed and random checks of btb_update_ctrl against a queue-based model
module tb_btb_update_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic flush_req;
  logic busy, sweep_done;

  btb_update_ctrl_if #(.INDEX_BITS(5), .TAG_BITS(5), .TGT_BITS(10)) bus ();

  btb_update_ctrl #(.DEPTH(4), .INDEX_BITS(5), .TAG_BITS(5), .TGT_BITS(10), .MAX_DEFER(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_req  (flush_req),
    .bus        (bus),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int tag;
    int tgt;
    bit taken;
  } ent_t;

  ent_t q[$];
  bit   m_sweep;
  int   m_sidx;
  int   m_defer;
  bit   m_done;
  bit   e_wr;
  bit   e_ready;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_sweep = 1'b1;
    m_sidx  = 0;
    m_defer = 0;
    m_done  = 1'b0;
  endtask

  // Called shortly after the falling edge, once inputs for this cycle are applied
  task automatic sample();
    bit f_known;
    int e_idx, e_tag, e_tgt;
    bit e_val, e_we;
    #1;
    e_idx = 0; e_tag = 0; e_tgt = 0; e_val = 1'b0; e_wr = 1'b0;
    if (m_sweep) begin
      e_we = 1'b1; e_idx = m_sidx; e_ready = 1'b0; f_known = 1'b1;
    end else begin
      e_ready = (q.size() < 4);
      e_wr = (q.size() > 0) &&
             (!(bus.lookup_valid && int'(bus.lookup_index) == q[0].idx) || m_defer == 3);
      if (e_wr) begin
        e_idx = q[0].idx; e_tag = q[0].tag; e_tgt = q[0].tgt; e_val = q[0].taken;
      end
      e_we = e_wr;
      f_known = e_wr || (q.size() == 0);
    end
    chk("btb_we", bus.btb_we, e_we);
    chk("res_ready", bus.res_ready, e_ready);
    chk("busy", busy, m_sweep || q.size() != 0);
    chk("sweep_done", sweep_done, m_done);
    if (f_known) begin
      chk("btb_windex", bus.btb_windex, e_idx);
      chk("btb_wtag", bus.btb_wtag, e_tag);
      chk("btb_wtarget", bus.btb_wtarget, e_tgt);
      chk("btb_wvalid", bus.btb_wvalid, e_val);
    end
  endtask

  task automatic advance();
    ent_t e;
    bit conf;
    if (flush_req) begin
      model_reset();
    end else if (m_sweep) begin
      m_done = (m_sidx == 31);
      if (m_sidx == 31) m_sweep = 1'b0;
      else m_sidx++;
    end else begin
      m_done = 1'b0;
      conf = (q.size() > 0) && bus.lookup_valid && int'(bus.lookup_index) == q[0].idx;
      if (e_wr) begin
        void'(q.pop_front());
        m_defer = 0;
      end else if (q.size() == 0) begin
        m_defer = 0;
      end else if (conf && m_defer < 3) begin
        m_defer++;
      end
      if (bus.res_valid && e_ready) begin
        e.idx   = int'(bus.res_addr[4:0]);
        e.tag   = int'(bus.res_addr[9:5]);
        e.tgt   = int'(bus.res_target[9:0]);
        e.taken = bus.res_taken;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_res(input bit v, input logic [63:0] a, input logic [63:0] t, input bit tk);
    bus.res_valid  = v;
    bus.res_addr   = a;
    bus.res_target = t;
    bus.res_taken  = tk;
  endtask

  task automatic set_lookup(input bit v, input int idx);
    bus.lookup_valid = v;
    bus.lookup_index = 5'(idx);
  endtask

  initial begin
    logic [63:0] a;
    reset = 1'b1;
    flush_req = 1'b0;
    set_res(1'b0, 64'h0, 64'h0, 1'b0);
    set_lookup(1'b0, 0);
    @(negedge clk);
    do_reset();

    // T1: full invalidate sweep after reset
    for (int i = 0; i < 32; i++) begin
      sample();
      chk("t1_sweep_index", bus.btb_windex, i);
      chk("t1_sweep_wvalid", bus.btb_wvalid, 0);
      advance();
    end
    sample();
    chk("t1_sweep_done", sweep_done, 1);
    chk("t1_ready_after", bus.res_ready, 1);
    advance();

    // T2: single taken push written the following cycle
    set_res(1'b1, 64'h1234, 64'h2A8, 1'b1);
    sample();
    chk("t2_no_write_on_push", bus.btb_we, 0);
    advance();
    set_res(1'b0, 64'h0, 64'h0, 1'b0);
    sample();
    chk("t2_we", bus.btb_we, 1);
    chk("t2_windex", bus.btb_windex, 64'h14);
    chk("t2_wtag", bus.btb_wtag, 64'h11);
    chk("t2_wtarget", bus.btb_wtarget, 64'h2A8);
    chk("t2_wvalid", bus.btb_wvalid, 1);
    advance();

    // T3: held conflict defers three cycles then forces the write
    set_lookup(1'b1, 'h14);
    set_res(1'b1, 64'h14, 64'h55, 1'b1);
    cycle();
    set_res(1'b0, 64'h0, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t3_deferred_we", bus.btb_we, 0);
      advance();
    end
    sample();
    chk("t3_forced_we", bus.btb_we, 1);
    advance();
    set_lookup(1'b0, 0);
    cycle();

    // T4: fill the FIFO under a held conflict, then drain in order
    set_lookup(1'b1, 3);
    for (int i = 0; i < 4; i++) begin
      set_res(1'b1, 64'((i << 5) | 3), 64'(256 + i), 1'b1);
      cycle();
    end
    set_res(1'b1, 64'h3E3, 64'h3FF, 1'b1);
    sample();
    chk("t4_full_ready", bus.res_ready, 0);
    advance();
    set_res(1'b0, 64'h0, 64'h0, 1'b0);
    set_lookup(1'b0, 0);
    for (int i = 0; i < 5; i++) cycle();

    // T5: flush drops queued entries and restarts the sweep
    set_lookup(1'b1, 9);
    set_res(1'b1, 64'h29, 64'h11, 1'b1);
    cycle();
    set_res(1'b1, 64'h49, 64'h22, 1'b1);
    cycle();
    flush_req = 1'b1;
    set_res(1'b1, 64'h69, 64'h33, 1'b1);
    cycle();
    flush_req = 1'b0;
    set_res(1'b0, 64'h0, 64'h0, 1'b0);
    set_lookup(1'b0, 0);
    for (int i = 0; i < 32; i++) begin
      sample();
      chk("t5_sweep_index", bus.btb_windex, i);
      chk("t5_sweep_wvalid", bus.btb_wvalid, 0);
      advance();
    end
    cycle();

    // T6: not-taken invalidate, then flush mid-sweep
    set_res(1'b1, 64'h7, 64'h3FF, 1'b0);
    cycle();
    set_res(1'b0, 64'h0, 64'h0, 1'b0);
    sample();
    chk("t6_we", bus.btb_we, 1);
    chk("t6_windex", bus.btb_windex, 7);
    chk("t6_wvalid", bus.btb_wvalid, 0);
    advance();
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    for (int i = 0; i < 17; i++) cycle();
    flush_req = 1'b1;
    sample();
    chk("t6_flush_at_17", bus.btb_windex, 17);
    advance();
    flush_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sample();
      chk("t6_restart_index", bus.btb_windex, i);
      advance();
    end
    cycle();

    // Random traffic with frequent index collisions
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        flush_req = ($urandom_range(0, 1) == 1);
        do_reset();
        flush_req = 1'b0;
      end
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[4:0] = 5'($urandom_range(0, 3));
      set_res($urandom_range(0, 2) != 0, a, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
      set_lookup($urandom_range(0, 1) == 1, $urandom_range(0, 3));
      flush_req = ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
